cia_sp_peer: RTL

//  External link partner for the SoC's CIA-style serial port (SP/CNT pins).

---
 rtl/cia_sp_peer_pkg.sv | 17 +
 rtl/cia_sp_peer_sync_edge_det.sv | 35 +++
 rtl/cia_sp_peer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cia_sp_peer_pkg.sv
// Shared definitions for the CIA-style serial-port peer: TX state encoding,
// bit-counter width and parameter defaults.
package cia_sp_peer_pkg;

  localparam int CNT_DIV_DEFAULT    = 4;     // clk cycles per CNT half-period on TX
  localparam int RX_TIMEOUT_DEFAULT = 1024;  // clk cycles before a partial RX byte is dropped

  localparam int                  BITCNT_W = 3;
  localparam logic [BITCNT_W-1:0] BIT_LAST = 3'd7;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2
  } tx_state_t;

endpackage

// File: rtl/cia_sp_peer_sync_edge_det.sv
// Synchronizes an asynchronous shift-clock/data pair into the clk domain.
// Both lines get a two-flop synchronizer that resets to 1 (idle level of the
// SP/CNT pins). The clock line also gets a registered rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic edge_in,    // asynchronous shift clock
  input  logic data_in,    // asynchronous serial data
  output logic data_sync,  // data after two flops
  output logic edge_rise   // one-cycle pulse per rising edge of edge_in
);

  logic edge_meta;
  logic edge_sync;
  logic data_meta;

  // Two-flop synchronizers; the edge pulse is registered straight from the
  // first/second stage so a pin rise shows up two clocks later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_meta <= 1'b1;
      edge_sync <= 1'b1;
      edge_rise <= 1'b0;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      edge_meta <= edge_in;
      edge_sync <= edge_meta;
      edge_rise <= edge_meta & ~edge_sync;
      data_meta <= data_in;
      data_sync <= data_meta;
    end
  end

endmodule

// File: rtl/cia_sp_peer.sv
// Board-side link partner for a CIA-style serial port.
// RX: samples sp_rx on each synchronized cnt_rx rising edge, MSB first, and
//     reports each complete byte with a one-cycle rx_valid pulse. A partial
//     byte is dropped after RX_TIMEOUT clocks without a CNT rise.
// TX: shifts tx_data out MSB first on sp_tx while generating cnt_tx, each
//     CNT half-period lasting CNT_DIV clocks. RX and TX run independently.
module cia_sp_peer
  import cia_sp_peer_pkg::*;
#(
  parameter int CNT_DIV    = CNT_DIV_DEFAULT,
  parameter int RX_TIMEOUT = RX_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sp_rx,
  input  logic       cnt_rx,
  output logic       sp_tx,
  output logic       cnt_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int                DIV_W     = $clog2(CNT_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CNT_DIV - 1);
  localparam int                IDLE_W    = $clog2(RX_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

  // ---------------------------------------------------------------- RX path
  logic                sp_sync;
  logic                cnt_rise;
  logic [7:0]          rx_shift;
  logic [BITCNT_W-1:0] rx_bitcnt;
  logic [IDLE_W-1:0]   idle_cnt;

  sync_edge_det u_rx_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .edge_in   (cnt_rx),
    .data_in   (sp_rx),
    .data_sync (sp_sync),
    .edge_rise (cnt_rise)
  );

  // Shift in one bit per CNT rise, publish the byte on the 8th, and drop a
  // stalled partial byte once the idle counter expires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_shift  <= '0;
      rx_bitcnt <= '0;
      idle_cnt  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (cnt_rise) begin
        idle_cnt <= '0;
        if (rx_bitcnt == BIT_LAST) begin
          rx_data   <= {rx_shift[6:0], sp_sync};
          rx_valid  <= 1'b1;
          rx_bitcnt <= '0;
        end else begin
          rx_shift  <= {rx_shift[6:0], sp_sync};
          rx_bitcnt <= rx_bitcnt + 1'b1;
        end
      end else if (rx_bitcnt != '0) begin
        if (idle_cnt == IDLE_LAST) begin
          rx_bitcnt <= '0;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t           state, state_d;
  logic [DIV_W-1:0]    div, div_d;
  logic [BITCNT_W-1:0] tbit, tbit_d;
  logic [7:0]          tx_shift, shift_d;
  logic                cnt_d, sp_d, ready_d;

  // TX state, divider, shifter and the registered pin/handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      div      <= '0;
      tbit     <= '0;
      tx_shift <= '0;
      cnt_tx   <= 1'b1;
      sp_tx    <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state    <= state_d;
      div      <= div_d;
      tbit     <= tbit_d;
      tx_shift <= shift_d;
      cnt_tx   <= cnt_d;
      sp_tx    <= sp_d;
      tx_ready <= ready_d;
    end
  end

  // Next-state logic; pin values are computed one cycle early so the
  // outputs come straight from flops.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state;
    div_d   = div;
    tbit_d  = tbit;
    shift_d = tx_shift;
    cnt_d   = cnt_tx;
    sp_d    = sp_tx;
    ready_d = tx_ready;
    unique case (state)
      TX_IDLE: begin
        cnt_d   = 1'b1;
        sp_d    = 1'b1;
        ready_d = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_d = tx_data;
          tbit_d  = '0;
          div_d   = '0;
          ready_d = 1'b0;
          cnt_d   = 1'b0;
          sp_d    = tx_data[7];
          state_d = TX_LOW;
        end
      end
      TX_LOW: begin
        if (div == DIV_LAST) begin
          div_d   = '0;
          cnt_d   = 1'b1;
          state_d = TX_HIGH;
        end else begin
          div_d = div + 1'b1;
        end
      end
      TX_HIGH: begin
        if (div == DIV_LAST) begin
          div_d = '0;
          if (tbit == BIT_LAST) begin
            cnt_d   = 1'b1;
            sp_d    = 1'b1;
            ready_d = 1'b1;
            state_d = TX_IDLE;
          end else begin
            // Next bit is presented together with the falling CNT edge so
            // it is stable for the whole LOW+HIGH period.
            shift_d = {tx_shift[6:0], 1'b0};
            tbit_d  = tbit + 1'b1;
            cnt_d   = 1'b0;
            sp_d    = tx_shift[6];
            state_d = TX_LOW;
          end
        end else begin
          div_d = div + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

endmodule
